sprite_fetch: RTL and testbench

SPRITE_FETCH -- requirements
Module: sprite_fetch

---
 rtl/sprite_fetch.sv | 158 +++++++++++++++
 tb/tb_sprite_fetch.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_fetch.sv
// +--------------------------------------------------------------------------+
// | sprite_fetch: per-pixel sprite-sheet ROM fetch, 3-clk pipeline.           |
// | Optional macro SPRITE_MIRROR_EN adds facing_left (horizontal mirroring).  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module sprite_fetch #(
  parameter int          CELL_W    = 48,
  parameter int          CELL_H    = 48,
  parameter int          SHEET_W   = 480,
  parameter logic [11:0] TRANS_KEY = 12'hF0F
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_start,
  input  logic [10:0] anim_row,
  input  logic [10:0] anim_col,
  input  logic [5:0]  max_width,
  input  logic [9:0]  pos_x,
  input  logic [9:0]  pos_y,
  input  logic [9:0]  vga_col,
  input  logic [9:0]  vga_row,
`ifdef SPRITE_MIRROR_EN
  input  logic        facing_left,
`endif
  output logic [16:0] rom_addr,
  input  logic [11:0] rom_data,
  output logic [11:0] pix_rgb,
  output logic        pix_valid
);

  localparam logic [9:0]  c_CELL_H10 = 10'(CELL_H);
  localparam logic [16:0] c_CELL_HA  = 17'(CELL_H);
  localparam logic [16:0] c_CELL_WA  = 17'(CELL_W);
  localparam logic [16:0] c_SHEET_WA = 17'(SHEET_W);

  // Shadow registers: frame-stable copies of the animation/position inputs
  logic [10:0] row_q, row_d;
  logic [10:0] col_q, col_d;
  logic [5:0]  maxw_q, maxw_d;
  logic [9:0]  posx_q, posx_d;
  logic [9:0]  posy_q, posy_d;
`ifdef SPRITE_MIRROR_EN
  logic        face_q, face_d;
`endif

  // Pipeline registers
  logic [5:0]  dx_q;
  logic [5:0]  dy_q;
  logic        hit0_q;
  logic [16:0] rom_addr_q, rom_addr_d;
  logic        hit1_q;
  logic        hit2_q;
  logic [11:0] pix_rgb_q;
  logic        pix_valid_q;

  logic [10:0] w_dx;
  logic [10:0] w_dy;
  logic        w_hit0;
  logic [5:0]  w_dx_eff;
  logic [16:0] w_addr;

  // The _d values already hold the new frame's settings when frame_start is
  // high, so stage 0 of a coincident pixel sees them directly.
  always_comb begin
    row_d  = row_q;
    col_d  = col_q;
    maxw_d = maxw_q;
    posx_d = posx_q;
    posy_d = posy_q;
`ifdef SPRITE_MIRROR_EN
    face_d = face_q;
`endif
    if (frame_start) begin
      row_d  = anim_row;
      col_d  = anim_col;
      maxw_d = max_width;
      posx_d = pos_x;
      posy_d = pos_y;
`ifdef SPRITE_MIRROR_EN
      face_d = facing_left;
`endif
    end
  end

  assign w_dx = {1'b0, vga_col} - {1'b0, posx_d};
  assign w_dy = {1'b0, vga_row} - {1'b0, posy_d};

  // Signed compare: a negative offset (sprite left/above) never wraps into a hit
  assign w_hit0 = ~w_dx[10] && (w_dx[9:0] < {4'd0, maxw_d}) &&
                  ~w_dy[10] && (w_dy[9:0] < c_CELL_H10);

  always_comb begin
    w_dx_eff = w_dx[5:0];
`ifdef SPRITE_MIRROR_EN
    if (face_d) begin
      w_dx_eff = maxw_d - 6'd1 - w_dx[5:0];
    end
`endif
  end

  // 17-bit modular arithmetic equals the full-width result truncated to 17 bits
  assign w_addr = (17'(row_q) * c_CELL_HA + 17'(dy_q)) * c_SHEET_WA +
                  17'(col_q) * c_CELL_WA + 17'(dx_q);

  always_comb begin
    rom_addr_d = rom_addr_q;
    if (hit0_q) begin
      rom_addr_d = w_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      row_q       <= '0;
      col_q       <= '0;
      maxw_q      <= '0;
      posx_q      <= '0;
      posy_q      <= '0;
`ifdef SPRITE_MIRROR_EN
      face_q      <= 1'b0;
`endif
      dx_q        <= '0;
      dy_q        <= '0;
      hit0_q      <= 1'b0;
      rom_addr_q  <= '0;
      hit1_q      <= 1'b0;
      hit2_q      <= 1'b0;
      pix_rgb_q   <= '0;
      pix_valid_q <= 1'b0;
    end else begin
      row_q       <= row_d;
      col_q       <= col_d;
      maxw_q      <= maxw_d;
      posx_q      <= posx_d;
      posy_q      <= posy_d;
`ifdef SPRITE_MIRROR_EN
      face_q      <= face_d;
`endif
      dx_q        <= w_dx_eff;
      dy_q        <= w_dy[5:0];
      hit0_q      <= w_hit0;
      rom_addr_q  <= rom_addr_d;
      hit1_q      <= hit0_q;
      hit2_q      <= hit1_q;
      pix_rgb_q   <= hit2_q ? rom_data : 12'h000;
      pix_valid_q <= hit2_q && (rom_data != TRANS_KEY);
    end
  end

  assign rom_addr  = rom_addr_q;
  assign pix_rgb   = pix_rgb_q;
  assign pix_valid = pix_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_sprite_fetch.sv
// +--------------------------------------------------------------------------+
// | tb_sprite_fetch: randomized scoreboard bench for sprite_fetch.            |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_sprite_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_start;
  logic [10:0] anim_row, anim_col;
  logic [5:0]  max_width;
  logic [9:0]  pos_x, pos_y, vga_col, vga_row;
  logic        facing_left;
  logic [16:0] rom_addr;
  logic [11:0] rom_data = 12'h000;
  logic [11:0] pix_rgb;
  logic        pix_valid;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  typedef struct { int due; logic [16:0] addr; } aexp_t;
  typedef struct { int due; logic v; logic [11:0] rgb; } pexp_t;
  aexp_t aq[$];
  pexp_t pq[$];

  always #5 clk = ~clk;

  sprite_fetch dut (
    .clk        (clk),
    .reset      (reset),
    .frame_start(frame_start),
    .anim_row   (anim_row),
    .anim_col   (anim_col),
    .max_width  (max_width),
    .pos_x      (pos_x),
    .pos_y      (pos_y),
    .vga_col    (vga_col),
    .vga_row    (vga_row),
`ifdef SPRITE_MIRROR_EN
    .facing_left(facing_left),
`endif
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .pix_rgb    (pix_rgb),
    .pix_valid  (pix_valid)
  );

  // Sprite ROM contents; every 7th address holds the transparent key
  function automatic logic [11:0] rom_f(input logic [16:0] a);
    int unsigned x;
    x = 32'(a);
    if (x % 7 == 3) return 12'hF0F;
    return 12'(x * 173 + (x >> 5) + 29);
  endfunction

  always @(posedge clk) rom_data <= rom_f(rom_addr);

  // Reference model: evaluates each requested pixel from the sheet geometry
  initial begin
    int sh_row, sh_col, sh_mw, sh_px, sh_py, sh_face;
    int dx, dy, dxe, a, last_addr;
    bit hit;
    logic [11:0] d;
    sh_row = 0; sh_col = 0; sh_mw = 0; sh_px = 0; sh_py = 0; sh_face = 0;
    last_addr = 0;
    forever begin
      @(posedge clk);
      cyc++;
      if (reset) begin
        sh_row = 0; sh_col = 0; sh_mw = 0; sh_px = 0; sh_py = 0; sh_face = 0;
        last_addr = 0;
        foreach (aq[i]) aq[i].addr = 17'd0;
        foreach (pq[i]) begin pq[i].v = 1'b0; pq[i].rgb = 12'h000; end
        aq.push_back('{due: cyc + 1, addr: 17'd0});
        pq.push_back('{due: cyc + 3, v: 1'b0, rgb: 12'h000});
      end else begin
        if (frame_start) begin
          sh_row = int'(anim_row); sh_col = int'(anim_col); sh_mw = int'(max_width);
          sh_px = int'(pos_x); sh_py = int'(pos_y); sh_face = int'(facing_left);
        end
        dx  = int'(vga_col) - sh_px;
        dy  = int'(vga_row) - sh_py;
        hit = (dx >= 0) && (dx < sh_mw) && (dy >= 0) && (dy < 48);
        if (hit) begin
          dxe = dx;
`ifdef SPRITE_MIRROR_EN
          if (sh_face != 0) dxe = sh_mw - 1 - dx;
`endif
          a = ((sh_row * 48 + dy) * 480 + sh_col * 48 + dxe) % 131072;
          last_addr = a;
          d = rom_f(17'(a));
          pq.push_back('{due: cyc + 3, v: (d != 12'hF0F), rgb: d});
        end else begin
          pq.push_back('{due: cyc + 3, v: 1'b0, rgb: 12'h000});
        end
        aq.push_back('{due: cyc + 1, addr: 17'(last_addr)});
      end
    end
  end

  // Monitor: compares whatever the DUT presents against due scoreboard entries
  initial begin
    aexp_t ea;
    pexp_t ep;
    forever begin
      @(negedge clk);
      if (aq.size() > 0 && aq[0].due == cyc) begin
        ea = aq.pop_front();
        n_checks++;
        if (rom_addr !== ea.addr) begin
          n_fail++;
          $display("FAIL rom_addr cyc=%0d got=%0d exp=%0d", cyc, rom_addr, ea.addr);
        end
      end
      if (pq.size() > 0 && pq[0].due == cyc) begin
        ep = pq.pop_front();
        n_checks++;
        if (pix_valid !== ep.v) begin
          n_fail++;
          $display("FAIL pix_valid cyc=%0d got=%0b exp=%0b", cyc, pix_valid, ep.v);
        end
        n_checks++;
        if (pix_rgb !== ep.rgb) begin
          n_fail++;
          $display("FAIL pix_rgb cyc=%0d got=%h exp=%h", cyc, pix_rgb, ep.rgb);
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic new_frame(input int r, input int c, input int mw, input int px,
                           input int py, input bit face);
    frame_start = 1'b1;
    anim_row = 11'(r); anim_col = 11'(c); max_width = 6'(mw);
    pos_x = 10'(px); pos_y = 10'(py); facing_left = face;
  endtask

  task automatic req(input int x, input int y);
    vga_col = 10'(x); vga_row = 10'(y);
    tick();
    frame_start = 1'b0;
  endtask

  initial begin
    int fpx, fpy, rst_len;
    reset = 1'b1; frame_start = 1'b0;
    anim_row = '0; anim_col = '0; max_width = '0;
    pos_x = '0; pos_y = '0; vga_col = '0; vga_row = '0; facing_left = 1'b0;
    @(negedge clk);

    // Reset held with frame_start toggling: must be ignored
    for (int i = 0; i < 4; i++) begin
      frame_start = i[0];
      anim_row = 11'd1; anim_col = 11'd2; max_width = 6'd48;
      pos_x = 10'd100; pos_y = 10'd50; vga_col = 10'd105; vga_row = 10'd53;
      tick();
    end
    reset = 1'b0; frame_start = 1'b0;
    for (int i = 0; i < 5; i++) req(105 + i, 53);

    // Known address case, then mid-frame anim_col change
    new_frame(1, 2, 48, 100, 50, 1'b0);
    req(105, 53);
    anim_col = 11'd3;
    req(105, 53);
    req(146, 50);
    req(99, 50);
    req(100, 97);
    req(100, 98);
    new_frame(1, 3, 46, 100, 50, 1'b0);
    req(146, 50);
    req(145, 50);
    req(105, 53);

    // Right-edge clipping: no wrap to column 0
    new_frame(0, 1, 48, 620, 100, 1'b0);
    req(0, 100);
    req(630, 100);
    req(639, 147);

    // Mirroring (no effect when the macro is off)
    new_frame(2, 4, 46, 200, 200, 1'b1);
    req(200, 200);
    req(245, 201);
    new_frame(2, 4, 0, 200, 200, 1'b0);
    req(200, 200);
    req(201, 210);

    // Mid-frame reset flush
    new_frame(0, 0, 40, 10, 10, 1'b0);
    req(12, 12);
    reset = 1'b1;
    req(13, 12);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) req(14 + i, 12);

    fpx = 100; fpy = 50;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 399) == 0) begin
        rst_len = int'($urandom_range(1, 4));
        reset = 1'b1;
        for (int k = 0; k < rst_len; k++) begin
          frame_start = 1'($urandom);
          tick();
        end
        reset = 1'b0;
      end
      if ($urandom_range(0, 49) == 0) begin
        fpx = int'($urandom_range(0, 639));
        fpy = int'($urandom_range(0, 479));
        new_frame(int'($urandom_range(0, 7)), int'($urandom_range(0, 9)),
                  ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 48)),
                  fpx, fpy, 1'($urandom));
      end else if ($urandom_range(0, 4) == 0) begin
        anim_row = 11'($urandom); anim_col = 11'($urandom);
        max_width = 6'($urandom); pos_x = 10'($urandom); pos_y = 10'($urandom);
        facing_left = 1'($urandom);
      end
      req(fpx + int'($urandom_range(0, 60)) - 6, fpy + int'($urandom_range(0, 54)) - 3);
    end

    for (int i = 0; i < 6; i++) req(0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
